// File: rtl/fifo_ctrl.sv
// fifo_ctrl: valid/ready FIFO controller driving an external Memory, with a 2-entry
// first-word-fall-through output stage that hides the Memory read latency.
module fifo_ctrl #(
    parameter int MEM_WIDTH_BYTES = 4,
    parameter int MEM_DEPTH       = 16,
    parameter bit SHOWAHEAD       = 1'b0,
    localparam int W  = MEM_WIDTH_BYTES * 8,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [AW-1:0] mem_write_addr_out,
    output logic          mem_write_out,
    output logic [W-1:0]  mem_data_out,
    output logic [AW-1:0] mem_read_addr_out,
    output logic          mem_read_out,
    input  logic [W-1:0]  mem_data_in,
    output logic [AW+1:0] count_out,
    output logic          full_out,
    output logic          empty_out,
    input  logic          debugen_in
);
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_in_flight;
    logic [1:0]    r_stage_cnt;
    logic [W-1:0]  r_stage0;
    logic [W-1:0]  r_stage1;
    logic [AW:0]   w_occ;
    logic          w_push;
    logic          w_pop;
    logic          w_rd_issue;
    logic          w_cap;
    logic [2:0]    w_stage_need;
    logic [1:0]    w_slot;

    assign w_occ        = r_wr_ptr - r_rd_ptr;
    assign full_out     = reset && (w_occ == (AW+1)'(MEM_DEPTH));
    assign in_ready     = reset && !full_out;
    assign w_push       = in_valid && in_ready;
    assign out_valid    = reset && (r_stage_cnt != 2'd0);
    assign w_pop        = out_valid && out_ready;
    // Reserve a stage slot for every word already in flight, net of this cycle's pop.
    assign w_stage_need = {1'b0, r_stage_cnt} + {2'b0, r_in_flight} - {2'b0, w_pop};
    assign w_rd_issue   = reset && (w_occ != '0) && (w_stage_need < 3'd2);
    assign w_cap        = SHOWAHEAD ? w_rd_issue : r_in_flight;
    assign w_slot       = r_stage_cnt - 2'(w_pop);

    assign mem_write_out      = w_push;
    assign mem_write_addr_out = r_wr_ptr[AW-1:0];
    assign mem_data_out       = in_data;
    assign mem_read_out       = w_rd_issue;
    assign mem_read_addr_out  = r_rd_ptr[AW-1:0];
    assign out_data           = r_stage0;
    assign count_out          = reset ? (AW+2)'(w_occ) + (AW+2)'(r_in_flight) + (AW+2)'(r_stage_cnt) : '0;
    assign empty_out          = (count_out == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_in_flight <= 1'b0;
            r_stage_cnt <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_in_flight <= !SHOWAHEAD && w_rd_issue;
            r_stage_cnt <= r_stage_cnt + 2'(w_cap) - 2'(w_pop);
            // Shift only with two entries so an emptied stage keeps showing the last word.
            if (w_pop && r_stage_cnt == 2'd2) r_stage0 <= r_stage1;
            if (w_cap && w_slot == 2'd0) r_stage0 <= mem_data_in;
            if (w_cap && w_slot == 2'd1) r_stage1 <= mem_data_in;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && debugen_in)
            $write("fifo_ctrl push=%0b pop=%0b rd=%0b wr_ptr=%0d rd_ptr=%0d stage=%0d\n",
                   w_push, w_pop, w_rd_issue, r_wr_ptr, r_rd_ptr, r_stage_cnt);
        if (reset)
            assert (!(w_cap && !w_pop && r_stage_cnt == 2'd2))
            else $error("fifo_ctrl: capture into full output stage");
    end
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl, one instance per SHOWAHEAD setting,
// each wired to its own Memory model and checked by its own in-order scoreboard.
module tb_fifo_ctrl;
    localparam int W = 32;
    localparam int AW = 4;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic debugen = 1'b0;
    logic [W-1:0] in_data = '0;

    always #5 clk = ~clk;

    logic in_ready0, out_valid0, we0, re0, full0, empty0;
    logic in_ready1, out_valid1, we1, re1, full1, empty1;
    logic [W-1:0] out_data0, wd0, rd0, out_data1, wd1, rd1;
    logic [AW-1:0] wa0, ra0, wa1, ra1;
    logic [AW+1:0] count0, count1;
    logic [W-1:0] mem0 [D];
    logic [W-1:0] mem1 [D];

    fifo_ctrl #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(D), .SHOWAHEAD(1'b0)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .mem_write_addr_out(wa0), .mem_write_out(we0), .mem_data_out(wd0),
        .mem_read_addr_out(ra0), .mem_read_out(re0), .mem_data_in(rd0),
        .count_out(count0), .full_out(full0), .empty_out(empty0), .debugen_in(debugen)
    );

    fifo_ctrl #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(D), .SHOWAHEAD(1'b1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .mem_write_addr_out(wa1), .mem_write_out(we1), .mem_data_out(wd1),
        .mem_read_addr_out(ra1), .mem_read_out(re1), .mem_data_in(rd1),
        .count_out(count1), .full_out(full1), .empty_out(empty1), .debugen_in(debugen)
    );

    // Registered-read memory refreshes its output every edge; show-ahead memory reads combinationally.
    always @(posedge clk) begin
        if (we0) mem0[wa0] <= wd0;
        rd0 <= mem0[ra0];
    end
    always @(posedge clk) if (we1) mem1[wa1] <= wd1;
    assign rd1 = mem1[ra1];

    int n_run = 0;
    int n_fail = 0;
    int p0 = 0;
    int p1 = 0;
    int k = 0;
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record the transfers that the coming edge will perform, then advance to 1 time unit past it.
    task automatic step();
        logic [W-1:0] e;
        #1;
        if (in_valid && in_ready0) q0.push_back(in_data);
        if (in_valid && in_ready1) q1.push_back(in_data);
        if (out_valid0 && out_ready) begin
            e = (q0.size() != 0) ? q0.pop_front() : 'x;
            chk("pop0", out_data0, e);
            p0++;
        end
        if (out_valid1 && out_ready) begin
            e = (q1.size() != 0) ? q1.pop_front() : 'x;
            chk("pop1", out_data1, e);
            p1++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held with a pushing producer
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1234;
        repeat (4) step();
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_mem_write", we0, 0);
        chk("rst_count", count0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_in_ready1", in_ready1, 0);
        chk("rst_q0", q0.size(), 0);
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        chk("post_rst_ready", in_ready0, 1);
        chk("post_rst_count", count0, 0);

        // Single word latency
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        out_ready = 1'b1;
        #1;
        chk("t2_we", we0, 1);
        chk("t2_wa", wa0, 0);
        step();
        in_valid = 1'b0;
        chk("t2_t0_valid0", out_valid0, 0);
        chk("t2_t0_valid1", out_valid1, 0);
        chk("t2_t0_count0", count0, 1);
        chk("t2_t0_count1", count1, 1);
        step();
        chk("t2_t1_valid0", out_valid0, 0);
        chk("t2_t1_count0", count0, 1);
        chk("t2_t1_valid1", out_valid1, 1);
        chk("t2_t1_data1", out_data1, 32'hDEADBEEF);
        step();
        chk("t2_t2_valid0", out_valid0, 1);
        chk("t2_t2_data0", out_data0, 32'hDEADBEEF);
        chk("t2_t2_count1", count1, 0);
        step();
        chk("t2_t3_count0", count0, 0);
        chk("t2_t3_valid0", out_valid0, 0);
        chk("t2_t3_empty0", empty0, 1);
        chk("t2_t3_hold0", out_data0, 32'hDEADBEEF);

        // Fill to full with the consumer stalled, then drain; three rounds wrap the pointers
        for (int f = 0; f < 3; f++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            k = 0;
            for (int i = 0; i < 30; i++) begin
                in_data = 32'(f * 256 + k);
                if (in_ready0) k++;
                step();
            end
            in_valid = 1'b0;
            chk("fill_accepted", k, 18);
            chk("fill_count0", count0, 18);
            chk("fill_full0", full0, 1);
            chk("fill_ready0", in_ready0, 0);
            chk("fill_count1", count1, 18);
            chk("fill_full1", full1, 1);
            out_ready = 1'b1;
            repeat (25) step();
            chk("drain_count0", count0, 0);
            chk("drain_empty0", empty0, 1);
            chk("drain_q0", q0.size(), 0);
            chk("drain_count1", count1, 0);
            chk("drain_q1", q1.size(), 0);
        end

        // Streaming one word per clock
        in_valid = 1'b1;
        out_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'(1000 + k);
            if (in_ready0) k++;
            step();
            if (i >= 3) begin
                chk("stream_valid0", out_valid0, 1);
                chk("stream_count0", count0, 3);
                chk("stream_valid1", out_valid1, 1);
                chk("stream_count1", count1, 2);
            end
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("stream_end0", count0, 0);
        chk("stream_end1", count1, 0);

        // Reset in the middle of operation
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 32'(500 + i);
            step();
        end
        in_valid = 1'b0;
        chk("mid_count0", count0, 7);
        chk("mid_count1", count1, 7);
        reset = 1'b0;
        step();
        chk("mid_rst_count0", count0, 0);
        chk("mid_rst_valid0", out_valid0, 0);
        chk("mid_rst_count1", count1, 0);
        q0.delete();
        q1.delete();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h55;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid0; i++) step();
        chk("mid_next_valid0", out_valid0, 1);
        chk("mid_next_data0", out_data0, 32'h55);
        repeat (4) step();
        chk("mid_end0", empty0, 1);
        chk("mid_end1", empty1, 1);

        // Random backpressure against both scoreboards
        p0 = 0;
        p1 = 0;
        for (int c = 0; c < 8000 && (p0 < 1000 || p1 < 1000); c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            step();
            chk("rand_bound0", count0 <= 6'd18, 1);
        end
        chk("rand_done0", p0 >= 1000, 1);
        chk("rand_done1", p1 >= 1000, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (25) step();
        chk("rand_q0", q0.size(), 0);
        chk("rand_q1", q1.size(), 0);
        chk("rand_count0", count0, 0);
        chk("rand_count1", count1, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
